// File: rtl/root_job_arbiter_if.sv
// Requester-side bundle for root_job_arbiter: job requests, one-hot accept, result pulse and busy.
interface root_job_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*10-1:0] req_base;
  logic [NUM_REQ*3-1:0]  req_exp;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [19:0]           rsp_data;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_base, req_exp,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_base, req_exp,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/root_job_arbiter.sv
// Round-robin sharing of one Q10.10 k-th root engine among NUM_REQ requesters, one job in flight.
// Optional engine watchdog enabled by defining ROOT_ARB_WATCHDOG_EN.
module root_job_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  root_job_arbiter_if.slave req_if,
  output logic              eng_in_valid,
  output logic [9:0]        eng_in_data_1,
  output logic [2:0]        eng_in_data_2,
  input  logic              eng_out_valid,
  input  logic [19:0]       eng_out_data,
  output logic              eng_rst_n
);
  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [PtrW-1:0] rr_q, rr_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [9:0]      base_q, base_d;
  logic [2:0]      exp_q, exp_d;
  logic [19:0]     data_q, data_d;

  logic            grant_any;
  logic [PtrW-1:0] grant_idx;
  logic [9:0]      grant_base;
  logic [2:0]      grant_exp;

`ifdef ROOT_ARB_WATCHDOG_EN
  logic [8:0] wd_q, wd_d;
  logic       abort_q, abort_d;
  logic       err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // Search starts just past the last owner so every requester gets a turn.
  always_comb begin
    logic [PtrW-1:0] idx;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_base = '0;
    grant_exp  = '0;
    idx        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = PtrW'((32'(rr_q) + k) % NUM_REQ);
      if (!grant_any && req_if.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_idx == PtrW'(i)) begin
        grant_base = req_if.req_base[10*i +: 10];
        grant_exp  = req_if.req_exp[3*i +: 3];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    base_d  = base_q;
    exp_d   = exp_q;
    data_d  = data_q;
`ifdef ROOT_ARB_WATCHDOG_EN
    wd_d    = wd_q;
    abort_d = 1'b0;
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (grant_any) begin
          owner_d = grant_idx;
          rr_d    = grant_idx;
          base_d  = grant_base;
          exp_d   = grant_exp;
`ifdef ROOT_ARB_WATCHDOG_EN
          err_d   = 1'b0;
`endif
          if (grant_exp != 3'd0) begin
            state_d = StIssue;
          end else begin
            state_d = StResp;
            data_d  = 20'h00400;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef ROOT_ARB_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      StWait: begin
        // A result arriving on the timeout cycle still wins.
        if (eng_out_valid) begin
          state_d = StResp;
          data_d  = eng_out_data;
        end
`ifdef ROOT_ARB_WATCHDOG_EN
        else if (wd_q == 9'(TIMEOUT_CYC - 1)) begin
          state_d = StResp;
          data_d  = '0;
          err_d   = 1'b1;
          abort_d = 1'b1;
        end else begin
          wd_d = wd_q + 9'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rr_q    <= PtrW'(NUM_REQ - 1);
      owner_q <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      data_q  <= '0;
`ifdef ROOT_ARB_WATCHDOG_EN
      wd_q    <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      data_q  <= data_d;
`ifdef ROOT_ARB_WATCHDOG_EN
      wd_q    <= wd_d;
      abort_q <= abort_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    req_if.req_ready = '0;
    req_if.rsp_valid = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (rst_n && state_q == StIdle && grant_any && grant_idx == PtrW'(i)) begin
        req_if.req_ready[i] = 1'b1;
      end
      if (state_q == StResp && owner_q == PtrW'(i)) begin
        req_if.rsp_valid[i] = 1'b1;
      end
    end
  end

  assign req_if.rsp_data = data_q;
  assign req_if.busy     = (state_q != StIdle);
  assign eng_in_valid    = (state_q == StIssue);
  assign eng_in_data_1   = base_q;
  assign eng_in_data_2   = exp_q;

`ifdef ROOT_ARB_WATCHDOG_EN
  assign req_if.rsp_err = err_q;
  assign eng_rst_n      = rst_n & ~abort_q;
`else
  assign req_if.rsp_err = 1'b0;
  assign eng_rst_n      = rst_n;
`endif
endmodule

// File: tb/tb_root_job_arbiter.sv
// Bench for root_job_arbiter: job-level timeline model checked every cycle, plus literal pins.
module tb_root_job_arbiter;
  localparam int NREQ = 4;
  localparam int TOUT = 20;

  typedef struct {
    int r;
    int base;
    int ex;
  } job_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eng_in_valid;
  logic [9:0]  eng_in_data_1;
  logic [2:0]  eng_in_data_2;
  logic        eng_out_valid;
  logic [19:0] eng_out_data;
  logic        eng_rst_n;

  always #5 clk = ~clk;

  root_job_arbiter_if #(.NUM_REQ(NREQ)) rif ();

  root_job_arbiter #(
    .NUM_REQ    (NREQ),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_if       (rif),
    .eng_in_valid (eng_in_valid),
    .eng_in_data_1(eng_in_data_1),
    .eng_in_data_2(eng_in_data_2),
    .eng_out_valid(eng_out_valid),
    .eng_out_data (eng_out_data),
    .eng_rst_n    (eng_rst_n)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  job_t pend[$];

  // Model: one job timeline (grant, issue, response cycle) plus its expected result.
  int m_rr = NREQ - 1;
  int m_owner = 0;
  int m_grant = -10;
  int m_issue = -10;
  int m_rsp = -10;
  int m_base = 0;
  int m_exp = 0;
  bit m_err = 1'b0;
  bit m_after_rst = 1'b0;
  logic [19:0] m_data = '0;

  int eng_due = -10;
  int eng_lat = 3;
  bit eng_mute = 1'b0;
  logic [19:0] eng_res = '0;

  int glog[$];
  int n_starts = 0;
  int obs_grant = 0;
  int obs_rsp = 0;
  int eng_rst_low = 0;
  int rsp_cnt[NREQ];
  int last_owner = -1;
  logic [19:0] last_data = '0;
  logic last_err = 1'b0;

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  function automatic logic [19:0] root_q(input int b, input int k);
    real r;
    if (k == 0) return 20'h00400;
    if (b == 0) return 20'h0;
    r = $pow(real'(b), 1.0 / real'(k));
    return 20'($rtoi(r * 1024.0 + 0.001));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NREQ; i++) begin
      int f;
      f = -1;
      for (int j = 0; j < pend.size(); j++) if (f < 0 && pend[j].r == i) f = j;
      if (f >= 0) begin
        rif.req_valid[i] = 1'b1;
        rif.req_base[10*i +: 10] = 10'(pend[f].base);
        rif.req_exp[3*i +: 3] = 3'(pend[f].ex);
      end else begin
        rif.req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic push_job(input int r, input int base, input int ex);
    job_t j;
    j.r = r;
    j.base = base;
    j.ex = ex;
    pend.push_back(j);
    drive_req();
  endtask

  task automatic check_and_model();
    logic [NREQ-1:0] er;
    logic [NREQ-1:0] ev;
    int w;
    if (!rst_n) begin
      chk("ready_in_reset", 32'(rif.req_ready), 32'h0);
      chk("eng_rst_in_reset", 32'(eng_rst_n), 32'h0);
      m_grant = -10;
      m_issue = -10;
      m_rsp = -10;
      m_err = 1'b0;
      m_rr = NREQ - 1;
      m_after_rst = 1'b1;
      eng_due = -10;
      return;
    end
    if (m_after_rst) begin
      chk("rst_data1", 32'(eng_in_data_1), 32'h0);
      chk("rst_data2", 32'(eng_in_data_2), 32'h0);
      chk("rst_rsp_data", 32'(rif.rsp_data), 32'h0);
      chk("rst_rsp_err", 32'(rif.rsp_err), 32'h0);
      m_after_rst = 1'b0;
    end
    w = -1;
    if (cyc > m_rsp) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_rr + k) % NREQ;
        if (w < 0 && rif.req_valid[idx]) w = idx;
      end
    end
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    ev = '0;
    if (cyc == m_rsp) ev[m_owner] = 1'b1;
    chk("req_ready", 32'(rif.req_ready), 32'(er));
    chk("busy", 32'(rif.busy), 32'(cyc > m_grant && cyc <= m_rsp));
    chk("eng_in_valid", 32'(eng_in_valid), 32'(cyc == m_issue));
    chk("rsp_valid", 32'(rif.rsp_valid), 32'(ev));
    chk("eng_rst_n", 32'(eng_rst_n), 32'(!(m_err && cyc == m_rsp)));
    if (cyc == m_rsp) begin
      chk("rsp_data", 32'(rif.rsp_data), 32'(m_data));
      chk("rsp_err", 32'(rif.rsp_err), 32'(m_err));
    end
    if (m_issue >= 0 && cyc >= m_issue && cyc <= m_rsp) begin
      chk("eng_data_1_hold", 32'(eng_in_data_1), 32'(m_base));
      chk("eng_data_2_hold", 32'(eng_in_data_2), 32'(m_exp));
    end
    // Observations for the literal pins.
    for (int i = 0; i < NREQ; i++) begin
      if (rif.req_ready[i]) begin
        glog.push_back(i);
        obs_grant = cyc;
      end
      if (rif.rsp_valid[i]) begin
        rsp_cnt[i]++;
        last_owner = i;
        last_data = rif.rsp_data;
        last_err = rif.rsp_err;
        obs_rsp = cyc;
      end
    end
    if (!eng_rst_n) eng_rst_low++;
    // Engine stand-in.
    if (!eng_rst_n) begin
      eng_due = -10;
    end else if (eng_in_valid) begin
      n_starts++;
      if (!eng_mute) begin
        eng_due = cyc + eng_lat;
        eng_res = root_q(int'(eng_in_data_1), int'(eng_in_data_2));
      end
    end
    if (w >= 0) begin
      int f;
      f = -1;
      for (int j = 0; j < pend.size(); j++) if (f < 0 && pend[j].r == w) f = j;
      m_base = pend[f].base;
      m_exp = pend[f].ex;
      pend.delete(f);
      m_owner = w;
      m_rr = w;
      m_grant = cyc;
      m_err = 1'b0;
      if (m_exp == 0) begin
        m_issue = -10;
        m_rsp = cyc + 1;
        m_data = 20'h00400;
      end else begin
        m_issue = cyc + 1;
        if (eng_mute) begin
          m_rsp = cyc + TOUT + 2;
          m_data = '0;
          m_err = 1'b1;
        end else begin
          m_rsp = cyc + eng_lat + 2;
          m_data = root_q(m_base, m_exp);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_and_model();
    @(posedge clk);
    cyc++;
    #1;
    drive_req();
    eng_out_valid = (cyc == eng_due);
    eng_out_data = (cyc == eng_due) ? eng_res : 20'hABCDE;
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((pend.size() > 0 || cyc <= m_rsp) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL run_budget cyc=%0d got=%0d want=<%0d", cyc, n, budget);
    end
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    int gsz;
    int r1;
    int exp_order[8];
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < NREQ; i++) rsp_cnt[i] = 0;
    rif.req_valid = '0;
    rif.req_base = '0;
    rif.req_exp = '0;
    eng_out_valid = 1'b0;
    eng_out_data = '0;
    step();
    step();
    rst_n = 1'b1;

    // Single job: 16 ^ (1/2) = 4.0.
    s0 = n_starts;
    push_job(0, 16, 2);
    run_until_done(200);
    chk("t1_data", 32'(last_data), 32'h01000);
    chk("t1_owner", last_owner, 0);
    chk("t1_err", 32'(last_err), 0);
    chk("t1_starts", n_starts - s0, 1);
    chk("t1_latency", obs_rsp - obs_grant, 5);

    // Saturation from reset: all four requesters hold two jobs each.
    do_reset();
    gsz = glog.size();
    eng_lat = 2;
    for (int j = 0; j < 8; j++) push_job(j % 4, 10 + j * 37, (j % 7) + 1);
    run_until_done(400);
    chk("t2_grants", glog.size() - gsz, 8);
    for (int j = 0; j < 8; j++) begin
      chk("t2_order", (glog.size() > gsz + j) ? glog[gsz+j] : -1, exp_order[j]);
    end

    // Exponent zero is answered locally.
    s0 = n_starts;
    push_job(2, 7, 0);
    run_until_done(50);
    chk("t3_data", 32'(last_data), 32'h00400);
    chk("t3_owner", last_owner, 2);
    chk("t3_starts", n_starts - s0, 0);
    chk("t3_latency", obs_rsp - obs_grant, 1);

    // Reset while waiting on the engine drops the job; rr restarts at 0.
    eng_lat = 10;
    push_job(1, 100, 2);
    repeat (4) step();
    r1 = rsp_cnt[1];
    push_job(3, 64, 3);
    push_job(0, 81, 2);
    do_reset();
    gsz = glog.size();
    run_until_done(200);
    chk("t4_first_grant", (glog.size() > gsz) ? glog[gsz] : -1, 0);
    chk("t4_second_grant", (glog.size() > gsz + 1) ? glog[gsz+1] : -1, 3);
    chk("t4_dropped_rsp", rsp_cnt[1] - r1, 0);

`ifdef ROOT_ARB_WATCHDOG_EN
    // Engine never answers: watchdog aborts after TOUT wait cycles.
    eng_lat = 3;
    eng_mute = 1'b1;
    s0 = eng_rst_low;
    push_job(2, 50, 2);
    run_until_done(100);
    chk("t5_err", 32'(last_err), 1);
    chk("t5_data", 32'(last_data), 0);
    chk("t5_eng_rst_pulse", eng_rst_low - s0, 1);
    chk("t5_latency", obs_rsp - obs_grant, TOUT + 2);
    eng_mute = 1'b0;
    push_job(3, 16, 2);
    run_until_done(100);
    chk("t5_next_data", 32'(last_data), 32'h01000);
    chk("t5_next_err", 32'(last_err), 0);
`endif

    // Spurious engine strobe while idle with a job pending is ignored.
    eng_lat = 3;
    push_job(1, 27, 3);
    eng_out_valid = 1'b1;
    eng_out_data = 20'hABCDE;
    run_until_done(100);
    chk("t6_data", 32'(last_data), 32'h00C00);
    chk("t6_owner", last_owner, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
